// File: rtl/abus_operand_stage.sv
// A-bus operand stage: decodes/overrides a source index, muxes the operand and hands it out via valid/ready.
// Optional ABUS_SKID_EN adds a skid entry so in_ready becomes a registered signal.
module abus_operand_stage #(
    parameter  int BITS    = 16,
    parameter  int OP_BITS = 5,
    parameter  int NUM_SRC = 4,
    localparam int EXT_W   = (NUM_SRC > 4) ? (NUM_SRC - 4) * BITS : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BITS-1:0]    a_out,
    input  logic [BITS-1:0]    w_out,
    input  logic [BITS-1:0]    pc,
    input  logic [EXT_W-1:0]   ext_src,
    input  logic [OP_BITS-1:0] opcode,
    input  logic               sel_ovr_en,
    input  logic [2:0]         sel_ovr,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BITS-1:0]    abus,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    localparam logic [3:0] NSRC = 4'(NUM_SRC);

    logic [7:0][BITS-1:0] srcs;
    logic [2:0]           dec_idx;
    logic [2:0]           eff_idx;
    logic                 idx_bad;
    logic [BITS-1:0]      in_data;
    logic                 accept;

    assign srcs[0] = a_out;
    assign srcs[1] = ~a_out;
    assign srcs[2] = w_out;
    assign srcs[3] = pc;

    // Slots beyond NUM_SRC read as zero, which is also the forwarded value for a bad index.
    genvar k;
    for (k = 4; k < 8; k++) begin : g_ext
        if (k < NUM_SRC) begin : g_used
            assign srcs[k] = ext_src[(k-4)*BITS +: BITS];
        end else begin : g_zero
            assign srcs[k] = '0;
        end
    end

    if (NUM_SRC == 4) begin : g_noext
        logic unused_ext;
        assign unused_ext = ^ext_src;
    end

    assign dec_idx[2] = 1'b0;
    assign dec_idx[1] = (opcode[3] & opcode[2] & ~opcode[1] & ~opcode[0]) |
                        (opcode[4] & opcode[3]) |
                        (opcode[4] & opcode[1] & opcode[0]);
    assign dec_idx[0] = opcode[4];

    assign eff_idx = sel_ovr_en ? sel_ovr : dec_idx;
    assign idx_bad = ({1'b0, eff_idx} >= NSRC);
    assign in_data = idx_bad ? '0 : srcs[eff_idx];
    assign accept  = in_valid & in_ready;

`ifdef ABUS_SKID_EN
    logic [BITS-1:0] skid_data;
    logic            skid_empty;

    assign in_ready = skid_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            abus       <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_empty <= 1'b1;
            sel_err    <= 1'b0;
        end else begin
            sel_err <= sel_err | (accept & idx_bad);
            if (!out_valid || out_ready) begin
                // A held skid entry always drains ahead of new requests (none accepted while full).
                if (!skid_empty) begin
                    abus       <= skid_data;
                    out_valid  <= 1'b1;
                    skid_empty <= 1'b1;
                end else begin
                    out_valid <= accept;
                    if (accept) abus <= in_data;
                end
            end else if (accept) begin
                skid_data  <= in_data;
                skid_empty <= 1'b0;
            end
        end
    end
`else
    assign in_ready = out_ready | ~out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            abus      <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= sel_err | (accept & idx_bad);
            if (!out_valid || out_ready) begin
                out_valid <= accept;
                if (accept) abus <= in_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_abus_operand_stage.sv
// Directed bench for abus_operand_stage: decode table, override/error vectors, streaming, stall and reset.
module tb_abus_operand_stage;

    localparam int BITS = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     a_out, w_out, pc;
    logic [31:0]     ext_src;
    logic [4:0]      opcode;
    logic            sel_ovr_en;
    logic [2:0]      sel_ovr;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     abus;
    logic            out_valid;
    logic            out_ready;
    logic            sel_err;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    abus_operand_stage #(.BITS(BITS), .OP_BITS(5), .NUM_SRC(6)) dut (
        .clk(clk), .rst(rst), .a_out(a_out), .w_out(w_out), .pc(pc),
        .ext_src(ext_src), .opcode(opcode), .sel_ovr_en(sel_ovr_en),
        .sel_ovr(sel_ovr), .in_valid(in_valid), .in_ready(in_ready),
        .abus(abus), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    typedef struct {
        logic [4:0]  op;
        logic        ovr_en;
        logic [2:0]  ovr;
        logic [15:0] exp_abus;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] q[$];
    int          acc;
    int          exp_acc;

    initial begin
        vecs[0] = '{5'b00000, 1'b0, 3'd0, 16'h00F0, 1'b0};
        vecs[1] = '{5'b10000, 1'b0, 3'd0, 16'hFF0F, 1'b0};
        vecs[2] = '{5'b01100, 1'b0, 3'd0, 16'h1234, 1'b0};
        vecs[3] = '{5'b11000, 1'b0, 3'd0, 16'h0040, 1'b0};
        vecs[4] = '{5'b10011, 1'b0, 3'd0, 16'h0040, 1'b0};
        vecs[5] = '{5'b00000, 1'b1, 3'd5, 16'hBEEF, 1'b0};
        vecs[6] = '{5'b00000, 1'b1, 3'd4, 16'hCAFE, 1'b0};
        vecs[7] = '{5'b11000, 1'b1, 3'd1, 16'hFF0F, 1'b0};
        vecs[8] = '{5'b00000, 1'b1, 3'd7, 16'h0000, 1'b1};
        vecs[9] = '{5'b00000, 1'b0, 3'd0, 16'h00F0, 1'b1};

        rst = 1'b1; a_out = 16'h00F0; w_out = 16'h1234; pc = 16'h0040;
        ext_src = {16'hBEEF, 16'hCAFE}; opcode = '0; sel_ovr_en = 1'b0;
        sel_ovr = '0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_abus", 32'(abus), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Decode / override table, one operand at a time with out_ready=1
        for (int i = 0; i < 10; i++) begin
            opcode = vecs[i].op; sel_ovr_en = vecs[i].ovr_en; sel_ovr = vecs[i].ovr;
            in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_abus", i), 32'(abus), 32'(vecs[i].exp_abus));
            chk($sformatf("vec%0d_sel_err", i), 32'(sel_err), 32'(vecs[i].exp_err));
            step();
        end
        chk("sticky_err_idle", 32'(sel_err), 32'd1);
        chk("drained_idle", 32'(out_valid), 32'd0);

        rst = 1'b1; step(); rst = 1'b0;
        chk("err_cleared", 32'(sel_err), 32'd0);

        // Ten back-to-back requests, one per cycle, in order
        sel_ovr_en = 1'b1; sel_ovr = 3'd2; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w_out = 16'(100 + i);
            in_valid = 1'b1;
            #1;
            chk($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            chk($sformatf("b2b%0d_abus", i), 32'(abus), 32'(100 + i));
            chk($sformatf("b2b%0d_valid", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("b2b_done", 32'(out_valid), 32'd0);

        // Three-cycle stall with continuous requests
`ifdef ABUS_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_out = 16'(200 + k);
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                q.push_back(w_out);
                acc++;
            end
            step();
            chk($sformatf("stall%0d_abus", k), 32'(abus), 32'h00C8);
            chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
        end
        chk("stall_accepted", 32'(acc), 32'(exp_acc));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                if (q.size() == 0) chk("drain_extra", 32'(abus), 32'hFFFF_FFFF);
                else chk($sformatf("drain%0d", c), 32'(abus), 32'(q.pop_front()));
            end
            step();
        end
        chk("drain_all", 32'(q.size()), 32'd0);

        // Reset while holding operands (output full, skid full in the skid build)
        sel_ovr = 3'd7; in_valid = 1'b1;
        step();
        sel_ovr = 3'd2;
        chk("pre_rst_err", 32'(sel_err), 32'd1);
        out_ready = 1'b0;
        step(); step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_abus", 32'(abus), 32'd0);
        chk("post_rst_err", 32'(sel_err), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        step();
        chk("post_rst_no_stale2", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/abus_operand_stage.md
ABUS_OPERAND_STAGE -- requirements
Module: abus_operand_stage

Interface
REQ-001 Parameter BITS, default 16: width of every data source and of the A bus.
REQ-002 Parameter OP_BITS, default 5: opcode width, SHALL be at least 5.
REQ-003 Parameter NUM_SRC, default 4, legal range 4..8: number of selectable A-bus sources.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 a_out  input  BITS  register-file A port, source 0.
REQ-007 w_out  input  BITS  writeback value, source 2.
REQ-008 pc  input  BITS  program counter, source 3.
REQ-009 ext_src  input  (NUM_SRC-4)*BITS (min 1)  extra sources 4..NUM_SRC-1, packed LSB-first, BITS each.
REQ-010 opcode  input  OP_BITS  instruction opcode for decode.
REQ-011 sel_ovr_en  input  1  when 1, sel_ovr replaces the opcode decode.
REQ-012 sel_ovr  input  3  explicit source index.
REQ-013 in_valid  input  1  operand request valid.
REQ-014 in_ready  output  1  stage can accept a request this cycle.
REQ-015 abus  output  BITS  registered A-bus value.
REQ-016 out_valid  output  1  abus holds a valid operand.
REQ-017 out_ready  input  1  consumer accepts abus this cycle.
REQ-018 sel_err  output  1  sticky flag, illegal source index accepted.

Function
REQ-019 Decoded index: bit1 = (op[3]&op[2]&~op[1]&~op[0]) | (op[4]&op[3]) | (op[4]&op[1]&op[0]); bit0 = op[4]; bit2 = 0.
REQ-020 Effective index = sel_ovr when sel_ovr_en=1, else the decoded index.
REQ-021 Source 1 SHALL be the bitwise inverse of a_out (all BITS bits), not a logical negation.
REQ-022 Request accepted on a cycle with in_valid=1 and in_ready=1; sources and index sampled on that edge.
REQ-023 Accepted value SHALL appear on abus with out_valid=1 exactly one cycle after acceptance when the output stage is empty.
REQ-024 Transfer out on a cycle with out_valid=1 and out_ready=1; abus and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Effective index >= NUM_SRC on acceptance: data 0 forwarded with normal handshake and sel_err set to 1, held until reset.
REQ-026 Operand order preserved; no request dropped or duplicated.
REQ-027 Simultaneous accept and transfer-out on a full output stage SHALL sustain one operand per cycle.

Reset
REQ-028 With rst=1 on an edge: out_valid=0, abus=0, sel_err=0, all buffer entries invalid; in_ready=1 on the following cycle.
REQ-029 rst mid-transfer SHALL discard every buffered operand; no operand from before reset appears after it.
REQ-030 A request presented during the reset cycle SHALL NOT be accepted.

Configuration
REQ-031 Macro ABUS_SKID_EN defined: a second skid entry is present; in_ready is a register output equal to "skid entry empty"; a stall on out_ready is absorbed by the skid entry, which drains to abus before any new request.
REQ-032 ABUS_SKID_EN undefined: single output register only; in_ready = out_ready | ~out_valid (combinational).
REQ-033 Both builds SHALL meet REQ-023 latency and REQ-027 throughput.

Verification
REQ-034 Opcodes 5'b00000, 5'b10000, 5'b01100, 5'b11000 with a_out=16'h00F0, w_out=16'h1234, pc=16'h0040, out_ready=1 -> abus 16'h00F0, 16'hFF0F, 16'h1234, 16'h0040, each one cycle after acceptance.
REQ-035 NUM_SRC=6, sel_ovr_en=1, sel_ovr=5, ext_src[31:16]=16'hBEEF -> abus 16'hBEEF, sel_err 0; sel_ovr=7 -> abus 16'h0000, sel_err 1 and remains 1.
REQ-036 10 back-to-back requests with out_ready=1 -> 10 operands in order, one per cycle, no in_ready deassertion.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 continuously -> abus stable; with ABUS_SKID_EN exactly 2 accepted then in_ready=0; without it exactly 1 accepted; after release all accepted operands delivered in order.
REQ-038 rst asserted for one cycle while out_valid=1 and skid entry full -> next cycle out_valid=0, abus=0, sel_err=0, in_ready=1.
